// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: direct-mapped write-back write-allocate cache controller; CACHE_STATS_EN adds hit/miss counters
module cache_ctrl_fsm #(
  parameter int TAG_W = 5,
  parameter int INDEX_W = 3,
  parameter int OFFSET_W = 2,
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_busy,
  output logic              hit,
  output logic              data_we,
  output logic              refill_we,
  output logic [INDEX_W-1:0] line_index,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              cnt_start,
  input  logic              cnt_done
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);
  typedef enum logic [2:0] {IDLE, COMPARE, WB_START, WB_WAIT, AL_START, AL_WAIT} state_t;
  state_t state, next;
  logic [TAG_W-1:0] tags [2**INDEX_W];
  logic [2**INDEX_W-1:0] valid, dirty;
  logic [TAG_W-1:0] tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic wr_q, match, req;
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];
  assign req = cpu_read | cpu_write;
  assign match = valid[idx_q] && tags[idx_q] == tag_q;
  assign cpu_busy = state != IDLE;
  assign line_index = idx_q;
  always_comb begin
    next = state;
    hit = 1'b0;
    data_we = 1'b0;
    refill_we = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    cnt_start = 1'b0;
    mem_addr = '0;
    case (state)
      IDLE: next = req ? COMPARE : IDLE;
      COMPARE: begin
        hit = match;
        data_we = match && wr_q;
        next = match ? IDLE : dirty[idx_q] ? WB_START : AL_START;
      end
      WB_START, WB_WAIT: begin
        cnt_start = state == WB_START;
        mem_write = 1'b1;
        mem_addr = {tags[idx_q], idx_q, {OFFSET_W{1'b0}}};
        next = state == WB_START ? WB_WAIT : cnt_done ? AL_START : WB_WAIT;
      end
      AL_START, AL_WAIT: begin
        cnt_start = state == AL_START;
        mem_read = 1'b1;
        mem_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
        refill_we = state == AL_WAIT && cnt_done;
        next = state == AL_START ? AL_WAIT : cnt_done ? COMPARE : AL_WAIT;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      tag_q <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      for (int i = 0; i < 2**INDEX_W; i++) tags[i] <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req) begin
        tag_q <= cpu_addr[ADDR_W-1 -: TAG_W];
        idx_q <= cpu_addr[OFFSET_W +: INDEX_W];
        wr_q <= cpu_write;
      end
      if (state == COMPARE && match && wr_q) dirty[idx_q] <= 1'b1;
      if (state == WB_WAIT && cnt_done) dirty[idx_q] <= 1'b0;
      if (state == AL_WAIT && cnt_done) begin
        tags[idx_q] <= tag_q;
        valid[idx_q] <= 1'b1;
        dirty[idx_q] <= 1'b0;
      end
    end
  end
`ifdef CACHE_STATS_EN
  // refilled marks the re-compare after a refill so it is not counted as a hit
  logic refilled;
  always_ff @(posedge clk) begin
    if (reset) begin
      refilled <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      refilled <= state == AL_WAIT && cnt_done ? 1'b1 : state == COMPARE ? 1'b0 : refilled;
      if (state == COMPARE && match && !refilled && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state == COMPARE && !match && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed checks of cache_ctrl_fsm with a latency-counter model answering cnt_start
module tb_cache_ctrl_fsm;
  logic clk = 0, reset = 1, cpu_read = 0, cpu_write = 0, cnt_done;
  logic [9:0] cpu_addr = '0, mem_addr;
  logic cpu_busy, hit, data_we, refill_we, mem_read, mem_write, cnt_start;
  logic [2:0] line_index;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  int tests = 0, fails = 0, cnt = 0;
  logic [31:0] v_busy, v_hit, v_dwe, v_rwe, v_mr, v_mw, v_cs;
  logic [9:0] a_log [32];

  cache_ctrl_fsm dut (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_busy(cpu_busy), .hit(hit), .data_we(data_we), .refill_we(refill_we), .line_index(line_index),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .cnt_start(cnt_start), .cnt_done(cnt_done)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // latency counter: done exactly 8 cycles after the start pulse
  assign cnt_done = cnt == 8;
  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else if (cnt == 8) cnt <= 0;
    else if (cnt != 0) cnt <= cnt + 1;
    else if (cnt_start) cnt <= 1;
  end

  task automatic snap(input int c);
    v_busy[c] = cpu_busy; v_hit[c] = hit; v_dwe[c] = data_we; v_rwe[c] = refill_we;
    v_mr[c] = mem_read; v_mw[c] = mem_write; v_cs[c] = cnt_start; a_log[c] = mem_addr;
  endtask

  task automatic req(input logic [9:0] a, input logic r, input logic w, input int n);
    {v_busy, v_hit, v_dwe, v_rwe, v_mr, v_mw, v_cs} = '0;
    @(negedge clk);
    cpu_addr = a; cpu_read = r; cpu_write = w;
    #1 snap(0);
    for (int c = 1; c < n; c++) begin
      @(negedge clk);
      cpu_read = 0; cpu_write = 0;
      #1 snap(c);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    tests++; if ({cpu_busy, hit, data_we, refill_we, mem_read, mem_write, cnt_start} !== 7'b0) begin fails++; $display("FAIL reset_ctrl got %b want 0", {cpu_busy, hit, data_we, refill_we, mem_read, mem_write, cnt_start}); end
    tests++; if ({line_index, mem_addr} !== 13'h0) begin fails++; $display("FAIL reset_addr got %h want 0", {line_index, mem_addr}); end
  endtask

  task automatic test_clean_miss;
    req(10'h000, 1, 0, 14);
    tests++; if (v_cs !== 32'h4) begin fails++; $display("FAIL miss_cnt_start got %h want 4", v_cs); end
    tests++; if (v_mr !== 32'h7FC) begin fails++; $display("FAIL miss_mem_read got %h want 7fc", v_mr); end
    tests++; if (v_rwe !== 32'h400) begin fails++; $display("FAIL miss_refill_we got %h want 400", v_rwe); end
    tests++; if (v_hit !== 32'h800) begin fails++; $display("FAIL miss_hit got %h want 800", v_hit); end
    tests++; if (v_busy !== 32'hFFE) begin fails++; $display("FAIL miss_busy got %h want ffe", v_busy); end
    tests++; if (v_mw !== 32'h0 || v_dwe !== 32'h0) begin fails++; $display("FAIL miss_no_wr got %h/%h want 0/0", v_mw, v_dwe); end
    tests++; if (a_log[2] !== 10'h000) begin fails++; $display("FAIL miss_mem_addr got %h want 000", a_log[2]); end
  endtask

  task automatic test_read_hit;
    req(10'h000, 1, 0, 4);
    tests++; if (v_hit !== 32'h2) begin fails++; $display("FAIL rhit_hit got %h want 2", v_hit); end
    tests++; if (v_cs !== 32'h0) begin fails++; $display("FAIL rhit_cnt_start got %h want 0", v_cs); end
    tests++; if (v_busy !== 32'h2) begin fails++; $display("FAIL rhit_busy got %h want 2", v_busy); end
  endtask

  task automatic test_write;
    req(10'h004, 0, 1, 14);
    tests++; if (v_dwe !== 32'h800 || v_hit !== 32'h800) begin fails++; $display("FAIL wmiss_dwe_hit got %h/%h want 800/800", v_dwe, v_hit); end
    req(10'h004, 1, 1, 4);
    tests++; if (v_dwe !== 32'h2 || v_hit !== 32'h2) begin fails++; $display("FAIL whit_dwe_hit got %h/%h want 2/2", v_dwe, v_hit); end
    tests++; if (v_busy !== 32'h2 || v_cs !== 32'h0) begin fails++; $display("FAIL whit_busy_cs got %h/%h want 2/0", v_busy, v_cs); end
  endtask

  task automatic test_dirty_miss;
    req(10'h024, 1, 0, 23);
    tests++; if (v_mw !== 32'h7FC) begin fails++; $display("FAIL dmiss_mem_write got %h want 7fc", v_mw); end
    tests++; if (v_cs !== 32'h804) begin fails++; $display("FAIL dmiss_cnt_start got %h want 804", v_cs); end
    tests++; if (v_mr !== 32'hFF800) begin fails++; $display("FAIL dmiss_mem_read got %h want ff800", v_mr); end
    tests++; if (a_log[2] !== 10'h004 || a_log[10] !== 10'h004) begin fails++; $display("FAIL dmiss_wb_addr got %h/%h want 004", a_log[2], a_log[10]); end
    tests++; if (a_log[11] !== 10'h024 || a_log[19] !== 10'h024) begin fails++; $display("FAIL dmiss_al_addr got %h/%h want 024", a_log[11], a_log[19]); end
    tests++; if (v_rwe !== 32'h80000 || v_hit !== 32'h100000) begin fails++; $display("FAIL dmiss_refill_hit got %h/%h want 80000/100000", v_rwe, v_hit); end
    tests++; if (v_busy !== 32'h1FFFFE) begin fails++; $display("FAIL dmiss_busy got %h want 1ffffe", v_busy); end
  endtask

  task automatic test_stats;
`ifdef CACHE_STATS_EN
    tests++; if (hit_count !== 16'd2 || miss_count !== 16'd3) begin fails++; $display("FAIL stats got %0d/%0d want 2/3", hit_count, miss_count); end
`endif
  endtask

  task automatic test_reset_mid;
    req(10'h05C, 1, 0, 6);
    tests++; if (v_mr !== 32'h3C) begin fails++; $display("FAIL rmid_pre got %h want 3c", v_mr); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    tests++; if ({cpu_busy, hit, data_we, refill_we, mem_read, mem_write, cnt_start} !== 7'b0) begin fails++; $display("FAIL rmid_ctrl got %b want 0", {cpu_busy, hit, data_we, refill_we, mem_read, mem_write, cnt_start}); end
    tests++; if ({line_index, mem_addr} !== 13'h0) begin fails++; $display("FAIL rmid_addr got %h want 0", {line_index, mem_addr}); end
    req(10'h000, 1, 0, 14);
    tests++; if (v_cs !== 32'h4 || v_hit !== 32'h800) begin fails++; $display("FAIL rmid_remiss got %h/%h want 4/800", v_cs, v_hit); end
    req(10'h05C, 1, 0, 14);
    tests++; if (v_cs !== 32'h4 || v_busy !== 32'hFFE) begin fails++; $display("FAIL rmid_remiss2 got %h/%h want 4/ffe", v_cs, v_busy); end
  endtask

  initial begin
    test_reset;
    test_clean_miss;
    test_read_hit;
    test_write;
    test_dirty_miss;
    test_stats;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Direct-mapped, write-back, write-allocate cache controller. It sits directly upstream of the memory-latency counter: it issues the counter's one-cycle start pulse and consumes the counter's done flag to time every memory block transfer. It holds the tag, valid and dirty arrays internally. It drives the enables for an external data array and the memory request lines.

Parameters:
TAG_W, 5, tag width in bits
INDEX_W, 3, index width in bits; number of lines = 2**INDEX_W
OFFSET_W, 2, word-offset width in bits; ADDR_W = TAG_W+INDEX_W+OFFSET_W (10 by default)

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
cpu_read  in  1  read request, sampled in IDLE
cpu_write  in  1  write request, sampled in IDLE
cpu_addr  in  ADDR_W  word address of the request
cpu_busy  out  1  high whenever state != IDLE
hit  out  1  one-cycle pulse in COMPARE on a tag match
data_we  out  1  one-cycle write-hit strobe to the data array
refill_we  out  1  one-cycle block-refill strobe to the data array
line_index  out  INDEX_W  latched index for the data array
mem_read  out  1  high throughout AL_START and AL_WAIT
mem_write  out  1  high throughout WB_START and WB_WAIT
mem_addr  out  ADDR_W  block address {tag, index, OFFSET_W'b0}
cnt_start  out  1  one-cycle start pulse to the latency counter
cnt_done  in  1  counter done; high for exactly one cycle, 8 cycles after the start pulse

Behaviour:
- Reset: state=IDLE; all valid and dirty bits cleared; tags zeroed; every output 0; latched address and op cleared. Reset wins over every other event, including mid-transfer. The counter shares reset.
- IDLE: if cpu_read|cpu_write, latch cpu_addr and op, then go to COMPARE. If both are high, the op is a write. Requests are ignored while cpu_busy=1, so the CPU need not hold them.
- COMPARE: hit = valid[idx] && tag[idx]==latched tag.
  - Hit, read: hit=1, go to IDLE.
  - Hit, write: hit=1, data_we=1, dirty[idx]<=1, go to IDLE.
  - Miss with dirty[idx]=1: go to WB_START.
  - Miss otherwise: go to AL_START.
- WB_START: cnt_start=1, mem_write=1, mem_addr={tag[idx], idx, 0}; go to WB_WAIT.
- WB_WAIT: hold mem_write and mem_addr. On cnt_done: dirty[idx]<=0, go to AL_START.
- AL_START: cnt_start=1, mem_read=1, mem_addr={latched tag, idx, 0}; go to AL_WAIT.
- AL_WAIT: hold mem_read. On cnt_done: refill_we=1, tag[idx]<=latched tag, valid[idx]<=1, dirty[idx]<=0, go to COMPARE. The re-compare then hits and applies a pending write.
- cnt_start is asserted only in the *_START states, one cycle each. It is never asserted in the cycle cnt_done is high, because the counter drops a start received at its terminal count. Going from WB_WAIT to AL_START guarantees the counter is idle (count 0) when the second pulse arrives.
- cnt_done outside WB_WAIT/AL_WAIT is ignored.
- Latency from the request cycle (cycle 0) to the first cycle cpu_busy=0:
  - Hit: 2 cycles.
  - Clean miss: 12 cycles; cnt_start in cycle 2, refill_we in cycle 10.
  - Dirty miss: 21 cycles.
- line_index and mem_addr are registered from the latched address. Outputs with no active condition are 0.

Optional Feature:
CACHE_STATS_EN:
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on every COMPARE hit that is not a post-refill re-compare.
  - miss_count increments on every COMPARE miss.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read 0x000 -> cnt_start=1 in cycle 2, mem_read high in cycles 2-10, mem_addr=0x000, refill_we in cycle 10, hit in cycle 11, cpu_busy=0 from cycle 12.
- Read 0x000 again -> hit=1 in cycle 1, no cnt_start, cpu_busy=0 in cycle 2.
- Write 0x004 (index 1, miss), then write 0x004 again -> second access: hit=1 and data_we=1 in cycle 1, dirty[1]=1.
- Read 0x024 (index 1, tag 1, dirty line) -> mem_write with mem_addr=0x004 in cycles 2-10, cnt_start in cycles 2 and 11, mem_read with mem_addr=0x024 in cycles 11-19, cpu_busy=0 in cycle 21.
- Assert reset during AL_WAIT -> next cycle: all outputs 0, state IDLE; a read to the same address misses again.
- With CACHE_STATS_EN defined, run the sequence above without the reset -> hit_count=2, miss_count=3.
